// File: rtl/phi_clk_switch_ctrl.sv
// rtl/phi_clk_switch_ctrl.sv - CPU clock handover sequencer between the fast clock and host PHI
module phi_clk_switch_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       host_phi,
    input  logic       en,
    input  logic       slow_req,
    input  logic       hold_slow,
    output logic       sel_slow,
    output logic       clk_gate_b,
    output logic       switch_done,
    output logic       timeout_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        FAST    = 3'd0,
        GATE_F  = 3'd1,
        ALIGN_S = 3'd2,
        SLOW    = 3'd3,
        GATE_S  = 3'd4,
        ALIGN_F = 3'd5
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [7:0] TC_LAST   = 8'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   armed_q;
    logic                   phi_s;
    logic                   fall_det;
    logic                   release_req;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [7:0] tcnt_q;
    logic [7:0] tcnt_d;
    logic       sel_d;
    logic       gate_d;
    logic       done_d;
    logic       terr_d;

    assign phi_s       = sync_q[SYNC_STAGES-1];
    // armed keeps the first post-reset sample from being read as an edge
    assign fall_det    = armed_q & prev_q & ~phi_s;
    assign release_req = (~slow_req & ~hold_slow) | ~en;
    assign state       = state_q;

    // Synchronise host PHI and keep the previous synchronised sample for edge detection
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], host_phi};
            prev_q  <= phi_s;
            armed_q <= 1'b1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= FAST;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            sel_slow    <= 1'b0;
            clk_gate_b  <= 1'b1;
            switch_done <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            sel_slow    <= sel_d;
            clk_gate_b  <= gate_d;
            switch_done <= done_d;
            timeout_err <= terr_d;
        end
    end

    // Next-state, counter and output decode; outputs derive from the next state so they register with it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        done_d  = 1'b0;
        terr_d  = timeout_err;
        case (state_q)
            FAST: begin
                if (en && slow_req) begin
                    state_d = GATE_F;
                    cnt_d   = HOLD_LOAD;
                end
            end
            GATE_F: begin
                if (cnt_q == 4'd0) begin
                    state_d = ALIGN_S;
                    tcnt_d  = 8'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ALIGN_S: begin
                if (fall_det) begin
                    state_d = SLOW;
                    done_d  = 1'b1;
                end else if (tcnt_q == TC_LAST) begin
                    state_d = ALIGN_F;
                    cnt_d   = HOLD_LOAD;
                    terr_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            SLOW: begin
                if (fall_det && release_req) begin
                    state_d = GATE_S;
                    cnt_d   = HOLD_LOAD;
                end
            end
            GATE_S: begin
                if (cnt_q == 4'd0) begin
                    state_d = ALIGN_F;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ALIGN_F: begin
                if (cnt_q == 4'd0) begin
                    state_d = FAST;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = FAST;
                cnt_d   = '0;
                tcnt_d  = '0;
            end
        endcase
        sel_d  = (state_d == SLOW) || (state_d == GATE_S);
        gate_d = (state_d == FAST) || (state_d == SLOW);
    end

endmodule

// File: tb/tb_phi_clk_switch_ctrl.sv
// tb/tb_phi_clk_switch_ctrl.sv - directed and stress bench for phi_clk_switch_ctrl
module tb_phi_clk_switch_ctrl;

    logic       clk;
    logic       rst_b;
    logic       host_phi;
    logic       en;
    logic       slow_req;
    logic       hold_slow;
    logic       sel_slow;
    logic       clk_gate_b;
    logic       switch_done;
    logic       timeout_err;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int phi_mode = 0;
    int phi_cnt = 0;
    int run_cnt = 0;
    int sel_changes = 0;
    logic sel_q = 1'b0;
    logic gate_q1 = 1'b1;
    logic gate_q2 = 1'b1;

    phi_clk_switch_ctrl #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(4),
        .TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .host_phi(host_phi),
        .en(en),
        .slow_req(slow_req),
        .hold_slow(hold_slow),
        .sel_slow(sel_slow),
        .clk_gate_b(clk_gate_b),
        .switch_done(switch_done),
        .timeout_err(timeout_err),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; sample 1 time unit after the edge, watch the mux-change rule, advance PHI
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_b) run_cnt = 0;
        else run_cnt++;
        if (run_cnt >= 3 && sel_slow !== sel_q) begin
            checks++;
            sel_changes++;
            if (gate_q1 !== 1'b0 || gate_q2 !== 1'b0) begin
                errors++;
                $display("FAIL sel_change_while_ungated: gate_prev=%b gate_prev2=%b required 0 0", gate_q1, gate_q2);
            end
        end
        gate_q2 = gate_q1;
        gate_q1 = clk_gate_b;
        sel_q   = sel_slow;
        if (phi_mode == 1) begin
            phi_cnt++;
            if (phi_cnt == 8) begin
                phi_cnt  = 0;
                host_phi = ~host_phi;
            end
        end else if (phi_mode == 2) begin
            if (phi_cnt == 0) begin
                host_phi = ~host_phi;
                phi_cnt  = int'($urandom_range(2, 12));
            end else begin
                phi_cnt--;
            end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0; host_phi = 1'b1; en = 1'b0; slow_req = 1'b0; hold_slow = 1'b0;
        repeat (3) step();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
        checks++; if (sel_slow !== 1'b0) begin errors++; $display("FAIL rst_sel: got %b expected 0", sel_slow); end
        checks++; if (clk_gate_b !== 1'b1) begin errors++; $display("FAIL rst_gate: got %b expected 1", clk_gate_b); end
        checks++; if (switch_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", switch_done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_terr: got %b expected 0", timeout_err); end
        rst_b = 1'b1;
        repeat (5) step();
        checks++; if (state !== 3'd0 || clk_gate_b !== 1'b1) begin errors++; $display("FAIL post_rst_idle: state=%0d gate=%b expected 0 1", state, clk_gate_b); end
    endtask

    task automatic test_switch_to_slow();
        int bad;
        en = 1'b1; slow_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (state !== 3'd1 || clk_gate_b !== 1'b0 || sel_slow !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL gate_f_phase: bad_cycles=%0d expected 0", bad); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (state !== 3'd2 || clk_gate_b !== 1'b0 || sel_slow !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL align_s_phase: bad_cycles=%0d expected 0", bad); end
        host_phi = 1'b0;
        step();
        step();
        checks++; if (state !== 3'd2 || sel_slow !== 1'b0) begin errors++; $display("FAIL align_s_before_edge: state=%0d sel=%b expected 2 0", state, sel_slow); end
        step();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL slow_state: got %0d expected 3", state); end
        checks++; if (sel_slow !== 1'b1 || clk_gate_b !== 1'b1) begin errors++; $display("FAIL slow_outputs: sel=%b gate=%b expected 1 1", sel_slow, clk_gate_b); end
        checks++; if (switch_done !== 1'b1) begin errors++; $display("FAIL slow_done_pulse: got %b expected 1", switch_done); end
        step();
        checks++; if (switch_done !== 1'b0 || state !== 3'd3) begin errors++; $display("FAIL slow_done_clear: done=%b state=%0d expected 0 3", switch_done, state); end
    endtask

    task automatic test_release();
        int bad;
        host_phi = 1'b1;
        repeat (4) step();
        slow_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (state !== 3'd3 || clk_gate_b !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL release_held_off: bad_cycles=%0d expected 0", bad); end
        host_phi = 1'b0;
        step();
        step();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL release_before_edge: got %0d expected 3", state); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (state !== 3'd4 || clk_gate_b !== 1'b0 || sel_slow !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL gate_s_phase: bad_cycles=%0d expected 0", bad); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (state !== 3'd5 || clk_gate_b !== 1'b0 || sel_slow !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL align_f_phase: bad_cycles=%0d expected 0", bad); end
        step();
        checks++; if (state !== 3'd0 || clk_gate_b !== 1'b1 || sel_slow !== 1'b0) begin errors++; $display("FAIL back_to_fast: state=%0d gate=%b sel=%b expected 0 1 0", state, clk_gate_b, sel_slow); end
        checks++; if (switch_done !== 1'b1) begin errors++; $display("FAIL fast_done_pulse: got %b expected 1", switch_done); end
        step();
        checks++; if (switch_done !== 1'b0) begin errors++; $display("FAIL fast_done_clear: got %b expected 0", switch_done); end
    endtask

    task automatic test_timeout();
        logic sel_seen;
        host_phi = 1'b1;
        repeat (4) step();
        slow_req = 1'b1;
        sel_seen = 1'b0;
        for (int n = 1; n <= 260; n++) begin
            step();
            if (sel_slow !== 1'b0) sel_seen = 1'b1;
            if (n == 4) begin
                checks++; if (state !== 3'd1) begin errors++; $display("FAIL to_gate_f_end: got %0d expected 1", state); end
            end
            if (n == 5) begin
                checks++; if (state !== 3'd2) begin errors++; $display("FAIL to_align_start: got %0d expected 2", state); end
            end
            if (n == 259) begin
                checks++; if (state !== 3'd2 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_before_expiry: state=%0d err=%b expected 2 0", state, timeout_err); end
            end
            if (n == 260) begin
                checks++; if (state !== 3'd5 || timeout_err !== 1'b1 || clk_gate_b !== 1'b0) begin errors++; $display("FAIL to_expiry: state=%0d err=%b gate=%b expected 5 1 0", state, timeout_err, clk_gate_b); end
            end
        end
        slow_req = 1'b0;
        repeat (3) step();
        checks++; if (state !== 3'd5 || clk_gate_b !== 1'b0) begin errors++; $display("FAIL to_align_f: state=%0d gate=%b expected 5 0", state, clk_gate_b); end
        step();
        checks++; if (state !== 3'd0 || clk_gate_b !== 1'b1 || switch_done !== 1'b1) begin errors++; $display("FAIL to_return_fast: state=%0d gate=%b done=%b expected 0 1 1", state, clk_gate_b, switch_done); end
        checks++; if (sel_seen !== 1'b0) begin errors++; $display("FAIL to_sel_never_set: got %b expected 0", sel_seen); end
    endtask

    task automatic test_en_block();
        int bad;
        en = 1'b0; slow_req = 1'b1; phi_mode = 1; phi_cnt = 0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (state !== 3'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL en_low_blocks: bad_cycles=%0d expected 0", bad); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL terr_sticky: got %b expected 1", timeout_err); end
    endtask

    task automatic test_hold_slow();
        int bad_sel, bad_gate, bad_done;
        en = 1'b1; hold_slow = 1'b1; slow_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (state == 3'd3) break;
        end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL hold_reach_slow: got %0d expected 3", state); end
        bad_sel = 0; bad_gate = 0; bad_done = 0;
        for (int i = 0; i < 160; i++) begin
            if (i % 3 == 0) slow_req = ~slow_req;
            step();
            if (sel_slow !== 1'b1) bad_sel++;
            if (clk_gate_b !== 1'b1) bad_gate++;
            if (switch_done !== 1'b0) bad_done++;
        end
        checks++; if (bad_sel != 0) begin errors++; $display("FAIL hold_sel: bad_cycles=%0d expected 0", bad_sel); end
        checks++; if (bad_gate != 0) begin errors++; $display("FAIL hold_gate: bad_cycles=%0d expected 0", bad_gate); end
        checks++; if (bad_done != 0) begin errors++; $display("FAIL hold_done: pulses=%0d expected 0", bad_done); end
    endtask

    task automatic test_reset_mid();
        hold_slow = 1'b0; slow_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (state == 3'd4) break;
        end
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL rm_reach_gate_s: got %0d expected 4", state); end
        #2;
        rst_b = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rm_state: got %0d expected 0", state); end
        checks++; if (sel_slow !== 1'b0 || clk_gate_b !== 1'b1) begin errors++; $display("FAIL rm_outputs: sel=%b gate=%b expected 0 1", sel_slow, clk_gate_b); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rm_terr_clear: got %b expected 0", timeout_err); end
        repeat (2) step();
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (state !== 3'd0 || switch_done !== 1'b0) begin errors++; $display("FAIL rm_after_release: state=%0d done=%b expected 0 0", state, switch_done); end
        end
    endtask

    task automatic test_stress();
        int bad, dones, sel_before;
        phi_mode = 2; phi_cnt = 5;
        bad = 0; dones = 0; sel_before = sel_changes;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0) slow_req = ~slow_req;
            if ($urandom_range(0, 15) == 0) hold_slow = ~hold_slow;
            step();
            if (state > 3'd5) bad++;
            if (switch_done === 1'b1) dones++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stress_state_legal: bad_cycles=%0d expected 0", bad); end
        checks++; if (dones == 0) begin errors++; $display("FAIL stress_switches: done_pulses=%0d expected >0", dones); end
        checks++; if (sel_changes == sel_before) begin errors++; $display("FAIL stress_sel_activity: changes=%0d expected >0", sel_changes - sel_before); end
    endtask

    initial begin
        test_reset();
        test_switch_to_slow();
        test_release();
        test_timeout();
        test_en_block();
        test_hold_slow();
        test_reset_mid();
        test_stress();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
